// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
//   Shared types and constants for the RV32I execute stage.
//   - XLEN / REGADDR datapath widths
//   - ALU operation and forwarding-select encodings
//   - packed records for the D->E and E->M pipeline registers
//   - fwd_mux(): operand forwarding selector shared by both ALU operands
// -----------------------------------------------------------------------------
package execute_stage_pkg;

  localparam int XLEN    = 32;
  localparam int REGADDR = 5;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [REGADDR-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRA = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Encoding 2'b11 is unused by the hazard unit and falls back to the
  // register-file operand.
  typedef enum logic [1:0] {
    FWD_REG      = 2'b00,
    FWD_RESULT_W = 2'b01,
    FWD_ALU_M    = 2'b10
  } fwd_sel_e;

  // Decoded instruction held in the D->E register.
  typedef struct packed {
    alu_op_e    alu_control;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    word_t      rd1;
    word_t      rd2;
    word_t      imm;
    word_t      pc;
    reg_idx_t   rd;
  } e_regs_t;

  // Result and controls held in the E->M register.
  typedef struct packed {
    word_t      alu_result;
    word_t      write_data;
    reg_idx_t   rd;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } m_regs_t;

  function automatic word_t fwd_mux(input logic [1:0] sel,
                                    input word_t      reg_val,
                                    input word_t      result_w,
                                    input word_t      alu_result_m);
    word_t val;
    case (sel)
      FWD_RESULT_W: val = result_w;
      FWD_ALU_M:    val = alu_result_m;
      default:      val = reg_val;
    endcase
    return val;
  endfunction

endpackage : execute_stage_pkg

// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   Bundles every non-clock signal of the execute stage.
//   slave  : view used by execute_stage (decode side in, memory side out)
//   master : view used by the surrounding pipeline / testbench
//   Groups:
//     decode -> E   : ValidD/ReadyD handshake, decoded controls, operands, PC, Rd
//     hazard unit   : FlushE, ForwardAE, ForwardBE, ResultW
//     fetch redirect: PCSrcE, PCTargetE
//     E -> memory   : ValidM/ReadyM handshake, ALUResultM, WriteDataM, RdM,
//                     RegWriteM, MemWriteM, ResultSrcM
// -----------------------------------------------------------------------------
interface execute_stage_if;
  import execute_stage_pkg::*;

  // decode -> execute
  logic       ValidD;
  logic       ReadyD;
  alu_op_e    ALUControlD;
  logic       ALUSrcD;
  logic       RegWriteD;
  logic       MemWriteD;
  logic [1:0] ResultSrcD;
  logic       BranchD;
  logic       JumpD;
  word_t      RD1D;
  word_t      RD2D;
  word_t      ImmExtD;
  word_t      PCD;
  reg_idx_t   RdD;

  // hazard unit
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  word_t      ResultW;

  // fetch redirect
  logic       PCSrcE;
  word_t      PCTargetE;

  // execute -> memory
  logic       ValidM;
  logic       ReadyM;
  word_t      ALUResultM;
  word_t      WriteDataM;
  reg_idx_t   RdM;
  logic       RegWriteM;
  logic       MemWriteM;
  logic [1:0] ResultSrcM;

  modport slave (
    input  ValidD, ALUControlD, ALUSrcD, RegWriteD, MemWriteD, ResultSrcD,
           BranchD, JumpD, RD1D, RD2D, ImmExtD, PCD, RdD,
           FlushE, ForwardAE, ForwardBE, ResultW, ReadyM,
    output ReadyD, PCSrcE, PCTargetE,
           ValidM, ALUResultM, WriteDataM, RdM, RegWriteM, MemWriteM, ResultSrcM
  );

  modport master (
    output ValidD, ALUControlD, ALUSrcD, RegWriteD, MemWriteD, ResultSrcD,
           BranchD, JumpD, RD1D, RD2D, ImmExtD, PCD, RdD,
           FlushE, ForwardAE, ForwardBE, ResultW, ReadyM,
    input  ReadyD, PCSrcE, PCTargetE,
           ValidM, ALUResultM, WriteDataM, RdM, RegWriteM, MemWriteM, ResultSrcM
  );

endinterface : execute_stage_if

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// execute_stage_alu
//   Purely combinational RV32I ALU. All results are XLEN-bit modulo.
//   Ports:
//     src_a, src_b  in   XLEN  operands
//     alu_control   in   3     operation (alu_op_e)
//     alu_result    out  XLEN  result
//     zero          out  1     alu_result == 0 (drives BEQ resolution)
// -----------------------------------------------------------------------------
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  word_t   src_a,
  input  word_t   src_b,
  input  alu_op_e alu_control,
  output word_t   alu_result,
  output logic    zero
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_signed;

  assign shamt     = src_b[SHAMT_W-1:0];
  assign lt_signed = $signed(src_a) < $signed(src_b);

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_NOT: alu_result = ~src_a;
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRA: alu_result = word_t'($signed(src_a) >>> shamt);
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, lt_signed};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule : execute_stage_alu

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   RV32I execute stage. Registers the decoded instruction (D->E), applies
//   operand forwarding, runs the ALU, resolves BEQ/JAL redirect and registers
//   the result for the memory stage (E->M). Both pipeline registers use a
//   valid/ready handshake so memory back-pressure stalls this stage.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous, active-high reset
//     bus   execute_stage_if.slave (decode handshake, hazard controls,
//           fetch redirect, memory handshake and registered results)
// -----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic    valid_e_q, valid_e_d;
  e_regs_t e_q, e_d;
  logic    valid_m_q, valid_m_d;
  m_regs_t m_q, m_d;

  // ---------------------------------------------------------------------------
  // Handshake: a register may load when it is empty or its consumer drains it.
  // ---------------------------------------------------------------------------
  logic adv_m;
  logic adv_e;
  logic live_e;   // E holds an instruction that has not been flushed

  assign adv_m  = ~valid_m_q | bus.ReadyM;
  assign adv_e  = ~valid_e_q | adv_m;
  assign live_e = valid_e_q & ~bus.FlushE;

  // ---------------------------------------------------------------------------
  // Execute datapath
  // ---------------------------------------------------------------------------
  word_t src_a;
  word_t fwd_b;
  word_t src_b;
  word_t alu_result;
  logic  zero;

  assign src_a = fwd_mux(bus.ForwardAE, e_q.rd1, bus.ResultW, m_q.alu_result);
  assign fwd_b = fwd_mux(bus.ForwardBE, e_q.rd2, bus.ResultW, m_q.alu_result);
  assign src_b = e_q.alu_src ? e_q.imm : fwd_b;

  execute_stage_alu u_alu (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (e_q.alu_control),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  // ---------------------------------------------------------------------------
  // E register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_e_d = valid_e_q;
    e_d       = e_q;
    if (adv_e) begin
      valid_e_d         = bus.ValidD & ~bus.FlushE;
      e_d.alu_control   = bus.ALUControlD;
      e_d.alu_src       = bus.ALUSrcD;
      e_d.reg_write     = bus.RegWriteD;
      e_d.mem_write     = bus.MemWriteD;
      e_d.result_src    = bus.ResultSrcD;
      e_d.branch        = bus.BranchD;
      e_d.jump          = bus.JumpD;
      e_d.rd1           = bus.RD1D;
      e_d.rd2           = bus.RD2D;
      e_d.imm           = bus.ImmExtD;
      e_d.pc            = bus.PCD;
      e_d.rd            = bus.RdD;
    end else if (bus.FlushE) begin
      // Stalled but flushed: kill the held instruction, payload is don't-care.
      valid_e_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // M register next state. Write enables are gated by the live-E qualifier so
  // a bubble or a flushed instruction never writes.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_m_d = valid_m_q;
    m_d       = m_q;
    if (adv_m) begin
      valid_m_d      = live_e;
      m_d.alu_result = alu_result;
      m_d.write_data = fwd_b;
      m_d.rd         = e_q.rd;
      m_d.reg_write  = e_q.reg_write & live_e;
      m_d.mem_write  = e_q.mem_write & live_e;
      m_d.result_src = e_q.result_src;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload registers are reset too, not just the valids, so
      // the M outputs read as zero out of reset; they are plain flops, not a
      // memory array, so the reset costs nothing structural.
      valid_e_q <= 1'b0;
      e_q       <= '0;
      valid_m_q <= 1'b0;
      m_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples its pre-edge next-state value, independent of statement order.
      valid_e_q <= valid_e_d;
      e_q       <= e_d;
      valid_m_q <= valid_m_d;
      m_q       <= m_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ReadyD     = adv_e;
  assign bus.PCSrcE     = live_e & ((e_q.branch & zero) | e_q.jump);
  assign bus.PCTargetE  = e_q.pc + e_q.imm;

  assign bus.ValidM     = valid_m_q;
  assign bus.ALUResultM = m_q.alu_result;
  assign bus.WriteDataM = m_q.write_data;
  assign bus.RdM        = m_q.rd;
  assign bus.RegWriteM  = m_q.reg_write;
  assign bus.MemWriteM  = m_q.mem_write;
  assign bus.ResultSrcM = m_q.result_src;

endmodule : execute_stage
